// File: rtl/synt_seq_ctrl_if.sv
// Control/synthesizer signal bundle for the SYNT power-up and calibration sequencer.
// master = sequencer side, slave = MAC/control FSM plus synthesizer side.
interface synt_seq_ctrl_if;
   logic       START;
   logic       TX_NRX;
   logic       STOP;
   logic       RDY_SYNT;
   logic       PU_SYNT;
   logic       CAL_SYNT;
   logic       PU_TX;
   logic       PU_RX;
   logic       BUSY;
   logic       LOCKED;
   logic       ERR;
   logic [1:0] RETRY_CNT;

   modport master (
      input  START, TX_NRX, STOP, RDY_SYNT,
      output PU_SYNT, CAL_SYNT, PU_TX, PU_RX, BUSY, LOCKED, ERR, RETRY_CNT
   );

   modport slave (
      output START, TX_NRX, STOP, RDY_SYNT,
      input  PU_SYNT, CAL_SYNT, PU_TX, PU_RX, BUSY, LOCKED, ERR, RETRY_CNT
   );
endinterface

// File: rtl/synt_seq_ctrl.sv
// SYNT power-up/calibration sequencer: settle, calibrate with timeout and bounded
// retries, lock-loss detection and abort. All outputs are registered state decodes.
module synt_seq_ctrl #(
   parameter int unsigned T_SETTLE  = 10,
   parameter int unsigned T_TIMEOUT = 100,
   parameter int unsigned T_OFF     = 5,
   parameter int unsigned MAX_RETRY = 2
) (
   input logic             CLK,
   input logic             RST,
   synt_seq_ctrl_if.master bus
);

   localparam int unsigned T_MAX0 = (T_SETTLE > T_TIMEOUT) ? T_SETTLE : T_TIMEOUT;
   localparam int unsigned T_MAX  = (T_MAX0 > T_OFF) ? T_MAX0 : T_OFF;
   localparam int unsigned CNT_W  = $clog2(T_MAX) + 1;

   localparam logic [CNT_W-1:0] CNT_SAT      = '1;
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(T_SETTLE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(T_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(T_OFF - 1);
   localparam logic [1:0]       RETRY_LIM    = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PWRUP,
      S_CAL,
      S_ACTIVE,
      S_RETRY_OFF,
      S_ERROR
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             mode_q;
   logic [1:0]       retry_q;
   logic             accept_c;
   logic             retry_c;

   // Next-state logic; STOP overrides everything outside IDLE, RDY_SYNT beats timeout.
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      retry_c  = 1'b0;
      if (bus.STOP && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_ERROR: begin
               if (bus.START) begin
                  state_d  = S_PWRUP;
                  accept_c = 1'b1;
               end
            end
            S_PWRUP: begin
               if (cnt_q == SETTLE_LAST) state_d = S_CAL;
            end
            S_CAL: begin
               if (bus.RDY_SYNT) begin
                  state_d = S_ACTIVE;
               end else if (cnt_q == TIMEOUT_LAST) begin
                  if (retry_q < RETRY_LIM) begin
                     state_d = S_RETRY_OFF;
                     retry_c = 1'b1;
                  end else begin
                     state_d = S_ERROR;
                  end
               end
            end
            S_ACTIVE: begin
               if (!bus.RDY_SYNT) state_d = S_ERROR;
            end
            S_RETRY_OFF: begin
               if (cnt_q == OFF_LAST) state_d = S_PWRUP;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, shared saturating cycle counter, mode/retry registers and output decodes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         mode_q       <= 1'b0;
         retry_q      <= 2'd0;
         bus.PU_SYNT  <= 1'b0;
         bus.CAL_SYNT <= 1'b0;
         bus.PU_TX    <= 1'b0;
         bus.PU_RX    <= 1'b0;
         bus.BUSY     <= 1'b0;
         bus.LOCKED   <= 1'b0;
         bus.ERR      <= 1'b0;
      end else begin
         state_q <= state_d;

         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (cnt_q != CNT_SAT) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         if (accept_c) begin
            mode_q  <= bus.TX_NRX;
            retry_q <= 2'd0;
         end else if (retry_c) begin
            retry_q <= retry_q + 2'd1;
         end

         // Decoding state_d keeps outputs aligned with the state they describe.
         bus.PU_SYNT  <= (state_d == S_PWRUP) || (state_d == S_CAL) || (state_d == S_ACTIVE);
         bus.CAL_SYNT <= (state_d == S_CAL);
         bus.PU_TX    <= (state_d == S_ACTIVE) && mode_q;
         bus.PU_RX    <= (state_d == S_ACTIVE) && !mode_q;
         bus.BUSY     <= (state_d == S_PWRUP) || (state_d == S_CAL) || (state_d == S_RETRY_OFF);
         bus.LOCKED   <= (state_d == S_ACTIVE);
         bus.ERR      <= (state_d == S_ERROR);
      end
   end

   assign bus.RETRY_CNT = retry_q;

endmodule

// File: doc/synt_seq_ctrl.md
# synt_seq_ctrl

Power-up and calibration sequencer for the frequency synthesizer, the `SYNT` block with ports `PU_SYNT`, `CAL_SYNT` and `RDY_SYNT`. On a start request it powers the synthesizer, waits a settle time, then holds calibration until the synthesizer reports ready. After that it enables the TX or RX front end. It sits between the MAC/control FSM and the synthesizer, and adds a calibration timeout, bounded retries, lock-loss detection and an abort path.

## Interface
Parameters:
- `T_SETTLE`, default 10: cycles in PWRUP before calibration starts (2 µs at 5 cycles/µs).
- `T_TIMEOUT`, default 100: maximum cycles in CAL waiting for `RDY_SYNT`.
- `T_OFF`, default 5: cycles with `PU_SYNT` low between retries.
- `MAX_RETRY`, default 2: retries after the first attempt before ERROR; range 0..3.

Ports:
- `CLK` input 1: clock. One clock; 5 cycles = 1 µs.
- `RST` input 1: reset. Synchronous and active-high.
- `START` input 1: start request pulse or level. Sampled only in IDLE or ERROR.
- `TX_NRX` input 1: 1 = TX, 0 = RX. Captured on the edge that accepts `START`.
- `STOP` input 1: abort or power down. Acts in every non-IDLE state.
- `RDY_SYNT` input 1: synthesizer ready.
- `PU_SYNT` output 1: synthesizer power-up.
- `CAL_SYNT` output 1: synthesizer calibration enable.
- `PU_TX` output 1: TX chain enable.
- `PU_RX` output 1: RX chain enable.
- `BUSY` output 1: high in PWRUP, CAL and RETRY_OFF.
- `LOCKED` output 1: high in ACTIVE.
- `ERR` output 1: high in ERROR.
- `RETRY_CNT` output 2: retries consumed in the current sequence.

## Operation
- All outputs are registered Moore decodes of the state register.
- Reset puts the FSM in IDLE with all outputs 0, `RETRY_CNT` = 0 and the mode register = 0.
- States and output decodes:
  - IDLE: all outputs 0.
  - PWRUP: `PU_SYNT` = 1.
  - CAL: `PU_SYNT` = 1, `CAL_SYNT` = 1.
  - ACTIVE: `PU_SYNT` = 1, `LOCKED` = 1, and `PU_TX` = mode or `PU_RX` = !mode.
  - RETRY_OFF: all power outputs 0, `BUSY` = 1.
  - ERROR: all power outputs 0, `ERR` = 1.
- Transitions:
  - IDLE to PWRUP on `START`. The mode is latched and `RETRY_CNT` is cleared.
  - PWRUP to CAL after exactly `T_SETTLE` cycles in PWRUP.
  - CAL to ACTIVE on the first cycle `RDY_SYNT` is sampled 1.
  - CAL times out on the `T_TIMEOUT`-th CAL cycle if `RDY_SYNT` is still 0:
    - If `RETRY_CNT` < `MAX_RETRY`, go to RETRY_OFF and increment `RETRY_CNT`.
    - Otherwise go to ERROR.
  - RETRY_OFF to PWRUP after exactly `T_OFF` cycles.
  - ACTIVE to ERROR if `RDY_SYNT` is sampled 0 (lock loss).
  - ERROR to PWRUP on `START`. The mode is re-latched and `RETRY_CNT` is cleared. `ERR` stays high until then.
  - Any state except IDLE goes to IDLE on `STOP`.
- Priorities:
  - `STOP` beats every other event, including `RDY_SYNT` and timeout on the same edge.
  - In CAL, `RDY_SYNT` = 1 beats timeout on the same edge.
  - `START` together with `STOP` in ERROR: `STOP` wins, go to IDLE.
- `START` in PWRUP, CAL, RETRY_OFF or ACTIVE is ignored. `TX_NRX` changes after acceptance are ignored.
- Counter:
  - One shared cycle counter, wide enough for max(`T_SETTLE`, `T_TIMEOUT`, `T_OFF`); 8 bits with the defaults.
  - Cleared on every state entry. Saturates; never wraps.
- Reset mid-sequence returns to IDLE at the next edge. `PU_SYNT` drops, so the synthesizer's internal timer reloads.

## Timing
- Edge 0 is the edge that samples `START`. `PU_SYNT` rises after edge 0, so latency is 1 cycle.
- `CAL_SYNT` rises after edge `T_SETTLE` (edge 10 with defaults).
- `LOCKED` and `PU_TX`/`PU_RX` rise 1 cycle after the edge at which `RDY_SYNT` is first sampled 1.
- `CAL_SYNT` falls together with the `LOCKED` rise.
- Timeout: `PU_SYNT` and `CAL_SYNT` fall after the `T_TIMEOUT`-th CAL edge.
- RETRY_OFF guarantees `PU_SYNT` is low for `T_OFF` ≥ 1 cycles, so the synthesizer resets.
- `STOP`: all outputs are 0 one cycle after the edge that samples it.
- No combinational path from any input to any output.

## Test plan
- Nominal TX with the `SYNT` model (12 µs ready):
  - `START` = 1, `TX_NRX` = 1 at edge 0.
  - Required: `PU_SYNT` high after edge 0, `CAL_SYNT` high after edge 10, `RDY_SYNT` high after edge 71.
  - Required: `LOCKED` = 1 and `PU_TX` = 1 after edge 72, `PU_RX` = 0, `RETRY_CNT` = 0.
- RX mode with `TX_NRX` toggled after acceptance -> `PU_RX` = 1 in ACTIVE; `PU_TX` stays 0 throughout.
- `RDY_SYNT` tied 0:
  - Required: three CAL windows of 100 cycles each, separated by 5-cycle `PU_SYNT`-low gaps.
  - Required: `RETRY_CNT` goes 1, then 2.
  - Required: `ERR` = 1 after the third timeout, and stays 1 until `START`, which clears `RETRY_CNT` to 0.
- Lock loss: in ACTIVE, force `RDY_SYNT` = 0 for 1 cycle -> `ERR` = 1 next cycle; `PU_TX` and `PU_SYNT` = 0.
- Simultaneous events:
  - `RDY_SYNT` rising on the 100th CAL edge -> ACTIVE, not a retry.
  - `STOP` on that same edge -> IDLE with all outputs 0.
- `RST` asserted in CAL at cycle 40 -> all outputs 0 next cycle. A subsequent `START` repeats the nominal timing exactly.
